// File: rtl/matrix_stream_input.sv
// matrix_stream_input: parses an ASCII "M N e0 e1 ..." matrix stream into BRAM writes with allocation, echo and commit.
module matrix_stream_input #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int DIM_WIDTH     = 4,
    parameter bit SIGNED_EN     = 1'b1,
    parameter int ALLOC_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode_active,
    input  logic [DIM_WIDTH-1:0]     config_max_dim,
    input  logic [ELEMENT_WIDTH-1:0] config_max_value,
    input  logic [7:0]               rx_data,
    input  logic                     rx_done,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     alloc_req,
    output logic [DIM_WIDTH-1:0]     alloc_m,
    output logic [DIM_WIDTH-1:0]     alloc_n,
    input  logic                     alloc_valid,
    input  logic                     alloc_fail,
    input  logic [3:0]               alloc_slot,
    input  logic [ADDR_WIDTH-1:0]    alloc_addr,
    output logic                     commit_req,
    output logic [3:0]               commit_slot,
    output logic [DIM_WIDTH-1:0]     commit_m,
    output logic [DIM_WIDTH-1:0]     commit_n,
    output logic [ADDR_WIDTH-1:0]    commit_addr,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
    output logic [3:0]               error_code,
    output logic [3:0]               sub_state,
    output logic                     busy
);
    localparam int AW = ELEMENT_WIDTH + 4;
    localparam int TW = 2 * DIM_WIDTH;
    localparam int CW = $clog2(ALLOC_TIMEOUT + 1);
    localparam logic [AW+3:0] ACC_MAX = {5'd0, {(AW-1){1'b1}}};

    typedef enum logic [3:0] {
        IDLE = 4'd0, PARSE_M = 4'd1, PARSE_N = 4'd2, CHECK_DIM = 4'd3, WAIT_ALLOC = 4'd4,
        PARSE_DATA = 4'd5, COMMIT = 4'd6, DONE = 4'd7, ERROR = 4'd8
    } state_t;

    state_t state, state_next;
    logic [AW-1:0] acc;
    logic [AW+3:0] prod;
    logic ovf, dig, neg, dim_bad, echo_full;
    logic [DIM_WIDTH-1:0] m, n;
    logic [TW-1:0] total, written;
    logic [CW-1:0] cnt;
    logic [3:0] slot, err_next;
    logic [ADDR_WIDTH-1:0] base;
    logic [7:0] echo_data;
    logic is_digit, is_delim, is_minus;
    logic acc_step, tok_clr, set_neg, latch_m, latch_n, got_alloc, do_wr, echo_ld, emit, send_d;

    assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
    assign is_delim = rx_data == 8'h20 || rx_data == 8'h2C || rx_data == 8'h0D || rx_data == 8'h0A;
    assign is_minus = rx_data == 8'h2D;
    assign prod     = {4'd0, acc} * (AW+4)'(10) + (AW+4)'(rx_data[3:0]);

    assign alloc_req   = state == WAIT_ALLOC;
    assign alloc_m     = m;
    assign alloc_n     = n;
    assign commit_req  = state == COMMIT;
    assign commit_slot = slot;
    assign commit_m    = m;
    assign commit_n    = n;
    assign commit_addr = base;
    assign sub_state   = state;
    assign busy        = !(state == IDLE || state == DONE || state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_next   = error_code;
        acc_step   = 1'b0;
        tok_clr    = 1'b0;
        set_neg    = 1'b0;
        latch_m    = 1'b0;
        latch_n    = 1'b0;
        got_alloc  = 1'b0;
        do_wr      = 1'b0;
        echo_ld    = 1'b0;
        emit       = 1'b0;
        send_d     = 1'b0;
        if (!mode_active) begin
            state_next = IDLE;
            err_next   = 4'd0;
        end else begin
            // tx_start is checked too so a UART that raises busy one cycle late never loses a byte
            emit = echo_full && !tx_busy && !tx_start;
            case (state)
                IDLE: begin
                    state_next = PARSE_M;
                    err_next   = 4'd0;
                end
                PARSE_M, PARSE_N: if (rx_done) begin
                    if (is_digit) begin
                        acc_step = 1'b1;
                        echo_ld  = 1'b1;
                    end else if (is_delim) begin
                        echo_ld = 1'b1;
                        if (dig) begin
                            tok_clr    = 1'b1;
                            latch_m    = state == PARSE_M;
                            latch_n    = state == PARSE_N;
                            state_next = state == PARSE_M ? PARSE_N : CHECK_DIM;
                        end
                    end else begin
                        state_next = ERROR;
                        err_next   = 4'd4;
                    end
                end
                CHECK_DIM: begin
                    state_next = WAIT_ALLOC;
                    if (dim_bad || m == '0 || n == '0 || m > config_max_dim || n > config_max_dim) begin
                        state_next = ERROR;
                        err_next   = 4'd1;
                    end
                end
                WAIT_ALLOC: begin
                    if (alloc_valid) begin
                        got_alloc  = 1'b1;
                        state_next = PARSE_DATA;
                    end else if (alloc_fail) begin
                        state_next = ERROR;
                        err_next   = 4'd3;
                    end else if (cnt == CW'(ALLOC_TIMEOUT - 1)) begin
                        state_next = ERROR;
                        err_next   = 4'd5;
                    end
                end
                PARSE_DATA: if (rx_done) begin
                    if (is_digit) begin
                        acc_step = 1'b1;
                        echo_ld  = 1'b1;
                    end else if (is_minus && SIGNED_EN && !dig && !neg) begin
                        set_neg = 1'b1;
                        echo_ld = 1'b1;
                    end else if (is_delim && dig) begin
                        if (ovf || acc > AW'(config_max_value)) begin
                            state_next = ERROR;
                            err_next   = 4'd2;
                        end else begin
                            do_wr      = 1'b1;
                            tok_clr    = 1'b1;
                            echo_ld    = 1'b1;
                            state_next = written + TW'(1) == total ? COMMIT : PARSE_DATA;
                        end
                    end else if (is_delim && !neg) begin
                        echo_ld = 1'b1;
                    end else begin
                        state_next = ERROR;
                        err_next   = 4'd4;
                    end
                end
                COMMIT: state_next = DONE;
                DONE: if (!echo_full && !tx_busy && !tx_start) begin
                    send_d     = 1'b1;
                    state_next = IDLE;
                end
                ERROR: state_next = ERROR;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_code  <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            echo_full   <= 1'b0;
            echo_data   <= '0;
            acc         <= '0;
            ovf         <= 1'b0;
            dig         <= 1'b0;
            neg         <= 1'b0;
            dim_bad     <= 1'b0;
            m           <= '0;
            n           <= '0;
            total       <= '0;
            written     <= '0;
            cnt         <= '0;
            slot        <= '0;
            base        <= '0;
        end else begin
            error_code <= err_next;
            mem_wr_en  <= do_wr;
            tx_start   <= emit || send_d;
            if (send_d) tx_data <= 8'h44;
            else if (emit) tx_data <= echo_data;
            if (!mode_active) echo_full <= 1'b0;
            else if (echo_ld) begin
                echo_full <= 1'b1;
                echo_data <= rx_data;
            end else if (emit) echo_full <= 1'b0;
            if (state == IDLE || tok_clr) begin
                acc <= '0;
                ovf <= 1'b0;
                dig <= 1'b0;
                neg <= 1'b0;
            end else if (acc_step) begin
                acc <= prod[AW-1:0];
                ovf <= ovf | (prod > ACC_MAX);
                dig <= 1'b1;
            end else if (set_neg) neg <= 1'b1;
            // a dimension that needs more than DIM_WIDTH bits is flagged before truncation
            if (state == IDLE) dim_bad <= 1'b0;
            else if (latch_m || latch_n) dim_bad <= dim_bad | ovf | (|acc[AW-1:DIM_WIDTH]);
            if (latch_m) m <= acc[DIM_WIDTH-1:0];
            if (latch_n) n <= acc[DIM_WIDTH-1:0];
            if (state == CHECK_DIM) total <= TW'(m) * TW'(n);
            cnt <= state == WAIT_ALLOC ? cnt + CW'(1) : '0;
            if (got_alloc) begin
                slot <= alloc_slot;
                base <= alloc_addr;
            end
            if (state == IDLE) written <= '0;
            else if (do_wr) written <= written + TW'(1);
            if (do_wr) begin
                mem_wr_addr <= base + ADDR_WIDTH'(written);
                mem_wr_data <= neg ? -acc[ELEMENT_WIDTH-1:0] : acc[ELEMENT_WIDTH-1:0];
            end
        end
    end
endmodule

// File: doc/matrix_stream_input.md
MATRIX_STREAM_INPUT -- requirements
Module: matrix_stream_input

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - ELEMENT_WIDTH, 8, stored element width (two's complement).
  - ADDR_WIDTH, 9, BRAM address width.
  - DIM_WIDTH, 4, width of M/N.
  - SIGNED_EN, 1, a leading '-' is accepted on element tokens.
  - ALLOC_TIMEOUT, 255, cycles to wait for allocation before failing.
REQ-002 Ports SHALL be (name direction width meaning):
  - clk in 1: the block's one clock.
  - rst_n in 1: reset, asynchronous, active-low.
  - mode_active in 1: block enable; low aborts to IDLE.
  - config_max_dim in DIM_WIDTH: max legal M and N.
  - config_max_value in ELEMENT_WIDTH: max legal |element|.
  - rx_data in 8, rx_done in 1: received byte, 1-cycle strobe.
  - tx_data out 8, tx_start out 1, tx_busy in 1: echo transmit.
  - alloc_req out 1, alloc_m out DIM_WIDTH, alloc_n out DIM_WIDTH: allocation request.
  - alloc_valid in 1, alloc_fail in 1, alloc_slot in 4, alloc_addr in ADDR_WIDTH: allocation response.
  - commit_req out 1, commit_slot out 4, commit_m out DIM_WIDTH, commit_n out DIM_WIDTH, commit_addr out ADDR_WIDTH: commit.
  - mem_wr_en out 1, mem_wr_addr out ADDR_WIDTH, mem_wr_data out ELEMENT_WIDTH: BRAM write.
  - error_code out 4, sub_state out 4, busy out 1: status.

Function
REQ-003 States SHALL be IDLE=0, PARSE_M=1, PARSE_N=2, CHECK_DIM=3, WAIT_ALLOC=4, PARSE_DATA=5, COMMIT=6, DONE=7, ERROR=8, driven on sub_state; unknown encoding -> IDLE.
REQ-004 Error codes SHALL be 0 none, 1 dim range, 2 value range, 3 no space, 4 bad char, 5 alloc timeout.
REQ-005 Delimiters SHALL be space, comma, CR (0x0D), LF (0x0A); a delimiter with an empty token is ignored.
REQ-006 Digits SHALL accumulate as acc = acc*10 + d in a register of ELEMENT_WIDTH+4 bits, with a sticky overflow flag set if any step exceeds 2^(ELEMENT_WIDTH+3)-1.
REQ-007 IDLE SHALL clear acc, counters, sign, overflow and error_code in one cycle, then go to PARSE_M.
REQ-008 PARSE_M/PARSE_N SHALL accept digits only; a delimiter ending a non-empty token latches the token and advances; any other byte -> ERROR, code 4.
REQ-009 CHECK_DIM SHALL go to ERROR, code 1, if M or N is 0, exceeds config_max_dim, or overflowed; otherwise it computes total=M*N (2*DIM_WIDTH bits), asserts alloc_req and goes to WAIT_ALLOC.
REQ-010 WAIT_ALLOC SHALL hold alloc_req high and count cycles from 0, as follows:
  - alloc_valid: latch slot/addr, drop alloc_req, go to PARSE_DATA.
  - alloc_fail: ERROR, code 3.
  - count reaching ALLOC_TIMEOUT: ERROR, code 5.
  - alloc_valid and alloc_fail together: alloc_valid wins.
REQ-011 PARSE_DATA SHALL accept '-' only as the first byte of a token when SIGNED_EN=1; otherwise '-' -> ERROR, code 4.
REQ-012 A token in PARSE_DATA SHALL end on a delimiter, and on the digit byte that makes the element count equal total only if that byte is followed by a delimiter; the final element needs a terminating delimiter.
REQ-013 On token end: if overflow or acc > config_max_value -> ERROR, code 2; else pulse mem_wr_en for 1 cycle with mem_wr_addr = base + written and mem_wr_data = sign ? -acc : acc (truncated to ELEMENT_WIDTH), then increment written.
REQ-014 When written reaches total, the next state SHALL be COMMIT; bytes arriving in COMMIT/DONE are ignored.
REQ-015 COMMIT SHALL pulse commit_req for exactly 1 cycle with the latched slot/M/N/addr; DONE then sends 'D' when !tx_busy and returns to IDLE.
REQ-016 Echo SHALL use a 1-entry holding register:
  - every accepted rx byte in PARSE_M/N/DATA loads it.
  - it is emitted as a 1-cycle tx_start when !tx_busy.
  - a new byte arriving while it is full overwrites it; echo is best-effort.
REQ-017 ERROR SHALL hold alloc_req=0, commit_req=0, keep error_code, and exit only when mode_active falls.
REQ-018 mode_active low SHALL, the next cycle, force IDLE, deassert alloc_req, commit_req, mem_wr_en and tx_start, and clear error_code; there is no commit of a partial matrix.
REQ-019 busy SHALL be 1 in every state except IDLE, DONE and ERROR.

Reset
REQ-020 On rst_n low, all outputs SHALL be 0, sub_state = IDLE, error_code = 0, and all internal registers cleared, with no dependence on clk.
REQ-021 Reset asserted mid-PARSE_DATA SHALL produce no further mem_wr_en or commit_req pulses.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - "2 3 1 2 3 4 5 6 " with max_dim=5, max_value=9, alloc_valid after 2 cycles -> writes 1..6 at base..base+5, one commit_req (M=2, N=3), 'D' echoed.
  - "2 2 -12,7 0 100 " with max_value=127, SIGNED_EN=1 -> data 0xF4, 0x07, 0x00, 0x64.
  - "6 2 " with max_dim=5 -> ERROR, code 1, no alloc_req.
  - "1 1 " with alloc held low for 255 cycles -> ERROR, code 5; separately alloc_fail -> code 3.
  - "1 2 3 x" -> ERROR, code 4 after one write; "1 1 200 " with max_value=127 -> code 2, no write.
  - rst_n pulsed after the 2nd element -> outputs 0 immediately, no commit.
